// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access-size codes,
// controller states, RAM read length and the misalignment predicate.
package lsu_pkg;

  localparam logic [1:0]  SZ_B      = 2'd0;
  localparam logic [1:0]  SZ_H      = 2'd1;
  localparam logic [1:0]  SZ_W      = 2'd2;
  localparam logic [31:0] RLEN_WORD = 32'd4;

  // Bit offset of a lane inside the word: byte lanes step by 8, half lanes by 16.
  localparam logic [2:0]  BYTE_LANE_SHIFT = 3'd3;
  localparam logic [3:0]  HALF_LANE_SHIFT = 4'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD,
    S_RMW_RD,
    S_ST_WR,
    S_RESP
  } state_e;

  // A half is misaligned on an odd address; a word (or reserved size)
  // is misaligned on any address that is not a multiple of four.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request/response and RAM-side signals of the load/store unit.
// master = execute stage plus data RAM; slave = lsu_ctrl.
interface lsu_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  logic              mem_valid;
  logic              mem_wen;
  logic [31:0]       mem_rlen;
  logic [ADDR_W-1:0] mem_raddr;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_valid, mem_wen, mem_rlen, mem_raddr, mem_waddr, mem_wdata
  );

  modport slave (
    input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_valid, mem_wen, mem_rlen, mem_raddr, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: sub-word load extract with sign/zero extension,
// and sub-word store merge into the previously read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        unsigned_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [4:0]  byte_off;
  logic [4:0]  half_off;

  // Halves only look at lane bit 1; words ignore the lane, so an
  // unaligned address is silently forced aligned here.
  assign byte_off = 5'(lane_i) << BYTE_LANE_SHIFT;
  assign half_off = 5'(lane_i[1]) << HALF_LANE_SHIFT;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    load_o  = rdata_i;
    store_o = wdata_i;
    byte_v  = '0;
    half_v  = '0;
    unique case (size_i)
      SZ_B: begin
        byte_v                = rdata_i[byte_off +: 8];
        load_o                = {{24{byte_v[7] & ~unsigned_i}}, byte_v};
        store_o               = old_i;
        store_o[byte_off +: 8] = wdata_i[7:0];
      end
      SZ_H: begin
        half_v                 = rdata_i[half_off +: 16];
        load_o                 = {{16{half_v[15] & ~unsigned_i}}, half_v};
        store_o                = old_i;
        store_o[half_off +: 16] = wdata_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time, read-modify-write for
// sub-word stores. Optional trap on misaligned access: LSU_MISALIGN_TRAP_EN.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  lsu_ctrl_if.slave  bus
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] old_q;
  logic [DATA_W-1:0] rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
  logic              err_q;
`endif

  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] store_word;
  logic [ADDR_W-1:0] word_addr;

  lsu_align u_align (
    .size_i     (size_q),
    .lane_i     (addr_q[1:0]),
    .unsigned_i (uns_q),
    .rdata_i    (bus.mem_rdata),
    .old_i      (old_q),
    .wdata_i    (wdata_q),
    .load_o     (load_word),
    .store_o    (store_word)
  );

  // NOTE: sequential state is assigned with non-blocking (<=) only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            wdata_q <= bus.req_wdata;
            rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q   <= 1'b0;
            if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
              err_q   <= 1'b1;
              state_q <= S_RESP;
            end else
`endif
            if (!bus.req_wen)
              state_q <= S_LD;
            else if (bus.req_size == SZ_B || bus.req_size == SZ_H)
              state_q <= S_RMW_RD;
            else
              state_q <= S_ST_WR;
          end
        end
        S_LD: begin
          rdata_q <= load_word;
          state_q <= S_RESP;
        end
        S_RMW_RD: begin
          old_q   <= bus.mem_rdata;
          state_q <= S_ST_WR;
        end
        S_ST_WR: state_q <= S_RESP;
        S_RESP:  if (bus.resp_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Enables are gated by rst so an in-flight write is cut off in the reset cycle itself.
  assign word_addr      = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.req_ready  = !rst && (state_q == S_IDLE);
  assign bus.mem_valid  = !rst && (state_q == S_LD || state_q == S_RMW_RD);
  assign bus.mem_wen    = !rst && (state_q == S_ST_WR);
  assign bus.mem_rlen   = bus.mem_valid ? RLEN_WORD : '0;
  assign bus.mem_raddr  = bus.mem_valid ? word_addr : '0;
  assign bus.mem_waddr  = bus.mem_wen   ? word_addr : '0;
  assign bus.mem_wdata  = bus.mem_wen   ? store_word : '0;
  assign bus.resp_valid = !rst && (state_q == S_RESP);
  assign bus.resp_rdata = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign bus.resp_err   = !rst && err_q;
`else
  assign bus.resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed test-plan steps followed by
// randomized traffic checked against a word-array reference model.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  lsu_ctrl_if bus ();

  lsu_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Data RAM: combinational read, full-word write on the clock edge; drops writes with bit 28 set.
  logic [31:0] ram [16];
  logic [31:0] ref_mem [16];
  logic        poke_en = 1'b0;
  logic [3:0]  poke_idx = '0;
  logic [31:0] poke_data = '0;

  assign bus.mem_rdata = ram[bus.mem_raddr[5:2]];

  always @(posedge clk) begin
    if (bus.mem_wen && !bus.mem_waddr[28]) ram[bus.mem_waddr[5:2]] <= bus.mem_wdata;
    else if (poke_en)                     ram[poke_idx] <= poke_data;
  end

  int          mv_cnt = 0;
  int          wen_cnt = 0;
  logic [31:0] last_raddr = '0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_rlen = '0;

  always @(posedge clk) begin
    if (bus.mem_valid) begin
      mv_cnt++;
      last_raddr = bus.mem_raddr;
      last_rlen  = bus.mem_rlen;
    end
    if (bus.mem_wen) begin
      wen_cnt++;
      last_waddr = bus.mem_waddr;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] d);
    poke_en   = 1'b1;
    poke_idx  = idx[3:0];
    poke_data = d;
    ref_mem[idx] = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Reference model, written from the access rules with shifts and masks.
  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                           input logic [1:0] size, input logic uns);
    logic [31:0] v;
    int          sh;
    if (size == 2'd0) begin
      sh = int'(addr[1:0]) * 8;
      v  = (word >> sh) & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      sh = int'(addr[1]) * 16;
      v  = (word >> sh) & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] addr,
                                            input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] mask;
    int          sh;
    if (size == 2'd0) begin
      sh   = int'(addr[1:0]) * 8;
      mask = 32'h0000_00FF << sh;
    end else begin
      sh   = int'(addr[1]) * 16;
      mask = 32'h0000_FFFF << sh;
    end
    return (old & ~mask) | ((wdata << sh) & mask);
  endfunction

  function automatic bit ref_misaligned(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd1) return addr[0] == 1'b1;
    if (size >= 2'd2) return addr[1:0] != 2'b00;
    return 1'b0;
  endfunction

  // One complete transaction: predicts result, latency and RAM activity, then checks them.
  task automatic exec(input string tag, input logic wen, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                      output logic [31:0] got);
    int          idx;
    bit          trap;
    logic [31:0] exp_rd;
    logic [31:0] new_word;
    int          exp_lat, exp_mv, exp_wen;
    int          mv0, w0, lat, n;

    idx      = int'(addr[5:2]);
    trap     = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap     = ref_misaligned(size, addr);
`endif
    new_word = ref_mem[idx];
    exp_rd   = '0;
    if (trap) begin
      exp_lat = 1; exp_mv = 0; exp_wen = 0;
    end else if (!wen) begin
      exp_rd  = ref_load(ref_mem[idx], addr, size, uns);
      exp_lat = 2; exp_mv = 1; exp_wen = 0;
    end else if (size == 2'd0 || size == 2'd1) begin
      new_word = ref_merge(ref_mem[idx], addr, size, wdata);
      exp_lat = 3; exp_mv = 1; exp_wen = 1;
    end else begin
      new_word = wdata;
      exp_lat = 2; exp_mv = 0; exp_wen = 1;
    end

    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ":req_ready"}, 32'(bus.req_ready), 32'd1);

    mv0 = mv_cnt;
    w0  = wen_cnt;
    bus.req_valid    = 1'b1;
    bus.req_wen      = wen;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ":rdata"},   bus.resp_rdata, exp_rd);
    check({tag, ":err"},     32'(bus.resp_err), 32'(trap));

    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ":hold_valid"}, 32'(bus.resp_valid), 32'd1);
      check({tag, ":hold_rdata"}, bus.resp_rdata, exp_rd);
      check({tag, ":hold_ready"}, 32'(bus.req_ready), 32'd0);
    end

    check({tag, ":mem_valid_cycles"}, 32'(mv_cnt - mv0), 32'(exp_mv));
    check({tag, ":mem_wen_pulses"},   32'(wen_cnt - w0), 32'(exp_wen));
    if (exp_mv != 0) begin
      check({tag, ":raddr"}, last_raddr, {addr[31:2], 2'b00});
      check({tag, ":rlen"},  last_rlen, 32'd4);
    end
    if (exp_wen != 0) check({tag, ":waddr"}, last_waddr, {addr[31:2], 2'b00});

    got = bus.resp_rdata;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check({tag, ":back_to_idle"}, 32'(bus.req_ready), 32'd1);
    check({tag, ":resp_dropped"}, 32'(bus.resp_valid), 32'd0);

    if (wen && !trap && !addr[28]) ref_mem[idx] = new_word;
  endtask

  initial begin
    logic [31:0] got;
    int          w0;

    bus.req_valid    = 1'b0;
    bus.req_wen      = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.resp_ready   = 1'b0;

    @(posedge clk); #1;
    check("rst:req_ready",  32'(bus.req_ready),  32'd0);
    check("rst:resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst:mem_valid",  32'(bus.mem_valid),  32'd0);
    check("rst:mem_wen",    32'(bus.mem_wen),    32'd0);
    check("rst:resp_err",   32'(bus.resp_err),   32'd0);

    for (int i = 0; i < 16; i++) poke(i, $urandom);
    poke(0, 32'h8077_F0A5);
    poke(1, 32'hAABB_CCDD);
    rst = 1'b0;
    #1;
    check("rst_release:req_ready", 32'(bus.req_ready), 32'd1);

    // Sub-word loads from word 0
    exec("lb_0",  1'b0, SZ_B, 1'b0, 32'h0, 32'h0, 0, got);
    check("lb_0:value", got, 32'hFFFF_FFA5);
    exec("lbu_1", 1'b0, SZ_B, 1'b1, 32'h1, 32'h0, 0, got);
    check("lbu_1:value", got, 32'h0000_00F0);
    exec("lh_2",  1'b0, SZ_H, 1'b0, 32'h2, 32'h0, 0, got);
    check("lh_2:value", got, 32'hFFFF_8077);

    // Word store then readback
    exec("sw_8", 1'b1, SZ_W, 1'b0, 32'h8, 32'h1234_5678, 0, got);
    check("sw_8:ram", ram[2], 32'h1234_5678);
    exec("lw_8", 1'b0, SZ_W, 1'b0, 32'h8, 32'h0, 0, got);
    check("lw_8:value", got, 32'h1234_5678);

    // Read-modify-write stores into word 1
    exec("sb_6", 1'b1, SZ_B, 1'b0, 32'h6, 32'h0000_00EE, 0, got);
    check("sb_6:ram", ram[1], 32'hAAEE_CCDD);
    exec("sh_4", 1'b1, SZ_H, 1'b0, 32'h4, 32'h0000_1111, 0, got);
    check("sh_4:ram", ram[1], 32'hAAEE_1111);

    // Response held off by the consumer
    exec("hold_lw_4", 1'b0, SZ_W, 1'b0, 32'h4, 32'h0, 5, got);
    check("hold_lw_4:value", got, 32'hAAEE_1111);

    // Store to an address the RAM ignores: issued unchanged, word 2 untouched
    exec("sw_bit28", 1'b1, SZ_W, 1'b0, 32'h1000_0008, 32'hDEAD_BEEF, 0, got);
    check("sw_bit28:ram", ram[2], 32'h1234_5678);

    // Reset during the write cycle of a byte store
    poke(3, 32'h0102_0304);
    bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_size = SZ_B;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'hC; bus.req_wdata = 32'h55;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_mid:in_write_cycle", 32'(bus.mem_wen), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid:wen_gated",   32'(bus.mem_wen),   32'd0);
    check("rst_mid:ready_low",   32'(bus.req_ready), 32'd0);
    w0 = wen_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_mid:no_write_edge", 32'(wen_cnt - w0), 32'd0);
    check("rst_mid:ram_unchanged", ram[3], 32'h0102_0304);
    check("rst_mid:ready_after",   32'(bus.req_ready), 32'd1);
    check("rst_mid:no_resp",       32'(bus.resp_valid), 32'd0);

    // Misaligned word load
    exec("lw_3", 1'b0, SZ_W, 1'b0, 32'h3, 32'h0, 0, got);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_3:value", got, 32'h0);
`else
    check("lw_3:value", got, 32'h8077_F0A5);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 80; i++) begin
      exec($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom,
           int'($urandom_range(0, 2)), got);
    end

    for (int i = 0; i < 16; i++) check($sformatf("final_ram%0d", i), ram[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
